// File: rtl/pc_delay_slot_unit.sv
// pc_delay_slot_unit
//   Program counter for the MIPS core with branch-delay-slot sequencing.
//   A redirect request (branch/jump/jr) first advances into the delay slot,
//   then loads the computed target on the following fetch step. Loading the
//   halt address or a misaligned target stops the unit until reset.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   active, fetch  : the PC advances only when both are high
//   branch_taken   : conditional branch resolved taken, offset in branch_off
//   jump           : J/JAL request, index in jump_index
//   jr             : JR/JALR request, target in jr_addr
//   pc_out         : current fetch address (registered)
//   link_addr      : pc_out + 8, combinational return address
//   delay_pending  : delay-slot instruction is being fetched
//   end_j          : redirect target loaded on the most recent step
//   halted         : sticky, unit stopped (halt address or trap)
//   addr_err       : sticky, misaligned redirect target
//   bis_err        : sticky, redirect requested inside a delay slot

module pc_delay_slot_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC0_0000),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              fetch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_addr,
    output logic              delay_pending,
    output logic              end_j,
    output logic              halted,
    output logic              addr_err,
    output logic              bis_err
);

    // Bits of the PC replaced by a J-type jump (instr_index plus word alignment).
    localparam logic [ADDR_W-1:0] JUMP_LOW_MASK = ADDR_W'(28'hFFF_FFFF);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] target_q;

    logic [ADDR_W-1:0] pc_plus4_c;
    logic [ADDR_W-1:0] jump_tgt_c;
    logic [ADDR_W-1:0] branch_tgt_c;
    logic [ADDR_W-1:0] target_c;
    logic              request_c;
    logic              step_c;

    // Sequential address and return address, both modulo 2^ADDR_W.
    assign pc_plus4_c = pc_out + ADDR_W'(4);
    assign link_addr  = pc_out + ADDR_W'(8);

    // J-type keeps the upper bits of the delay-slot PC (pc+4).
    assign jump_tgt_c   = (pc_plus4_c & ~JUMP_LOW_MASK)
                        | ADDR_W'({jump_index, 2'b00});
    assign branch_tgt_c = pc_plus4_c + (branch_off << 2);

    // Redirect target selection: jr beats jump beats branch.
    always_comb begin
        target_c = branch_tgt_c;
        if (jr) begin
            target_c = jr_addr;
        end else if (jump) begin
            target_c = jump_tgt_c;
        end
    end

    assign request_c = jr | jump | branch_taken;
    assign step_c    = active & fetch & (state != ST_HALT);

    // PC sequencing FSM; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            pc_out        <= RESET_VECTOR;
            target_q      <= '0;
            delay_pending <= 1'b0;
            end_j         <= 1'b0;
            halted        <= 1'b0;
            addr_err      <= 1'b0;
            bis_err       <= 1'b0;
        end else if (step_c) begin
            case (state)
                ST_RUN: begin
                    pc_out <= pc_plus4_c;
                    end_j  <= 1'b0;
                    if (request_c) begin
                        // Fetch the delay slot now, redirect on the next step.
                        target_q      <= target_c;
                        delay_pending <= 1'b1;
                        state         <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    pc_out        <= target_q;
                    delay_pending <= 1'b0;
                    end_j         <= 1'b1;
                    // A redirect from the delay-slot instruction is dropped.
                    if (request_c) begin
                        bis_err <= 1'b1;
                    end
                    if (target_q == HALT_ADDR) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (target_q[1:0] != 2'b00) begin
                        addr_err <= 1'b1;
                        halted   <= 1'b1;
                        state    <= ST_HALT;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule
